// File: rtl/packet_output_arbiter.sv
// ---------------------------------------------------------------------------
// packet_output_arbiter
//
// Purpose:
//   Downstream stage for a group of packet buffers. It watches each buffer's
//   packet/command readiness and header fields and picks one buffer at a
//   time in round-robin order. The chosen buffer gets a single-cycle stream
//   or drop command. A streamed packet's flits are forwarded onto one output
//   link. Only one packet is ever in flight toward the link, so the output
//   never collides and needs no back-pressure.
//
// Ports:
//   clk_i             clock; all logic runs on the rising edge
//   rst_i             synchronous active-high reset
//   packet_ready_i    [N]       buffer i holds a complete packet
//   control_ready_i   [N]       buffer i can accept a command
//   to_addr_i         [N*AW]    destination address of buffer i's head packet
//   packet_length_i   [N*LW]    length in flits of buffer i's head packet
//   in_flit_i         [N*FS]    flit data streamed out by buffer i
//   in_flit_valid_i   [N]       flit valid from buffer i
//   control_valid_o   [N]       one-hot command strobe
//   stream_o          [N]       stream command, qualified by control_valid_o
//   drop_o            [N]       drop command, qualified by control_valid_o
//   out_flit_o        [FS]      output link data
//   out_flit_valid_o            output link valid
//   busy_o                      high while a packet is streaming
//   timeout_err_o               sticky; a stream was aborted on inactivity
//   pkts_streamed_o   [16]      wrapping count of completed streams
//   pkts_dropped_o    [16]      wrapping count of drop commands
// ---------------------------------------------------------------------------
module packet_output_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int FLIT_SIZE  = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ADDR_LO    = 0,
    parameter int ADDR_HI    = 255,
    parameter int MAX_LEN    = 255,
    parameter int TIMEOUT    = 1023
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_INPUTS-1:0]              packet_ready_i,
    input  logic [N_INPUTS-1:0]              control_ready_i,
    input  logic [N_INPUTS*ADDR_WIDTH-1:0]   to_addr_i,
    input  logic [N_INPUTS*LEN_WIDTH-1:0]    packet_length_i,
    input  logic [N_INPUTS*FLIT_SIZE-1:0]    in_flit_i,
    input  logic [N_INPUTS-1:0]              in_flit_valid_i,
    output logic [N_INPUTS-1:0]              control_valid_o,
    output logic [N_INPUTS-1:0]              stream_o,
    output logic [N_INPUTS-1:0]              drop_o,
    output logic [FLIT_SIZE-1:0]             out_flit_o,
    output logic                             out_flit_valid_o,
    output logic                             busy_o,
    output logic                             timeout_err_o,
    output logic [15:0]                      pkts_streamed_o,
    output logic [15:0]                      pkts_dropped_o
);

    localparam int IdxW  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int CntW  = LEN_WIDTH + 1;
    localparam int IdleW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdleW-1:0]       idle_cnt_q, idle_cnt_d;
    logic [FLIT_SIZE-1:0]   out_flit_q, out_flit_d;
    logic                   out_flit_valid_q, out_flit_valid_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [15:0]            pkts_streamed_q, pkts_streamed_d;
    logic [15:0]            pkts_dropped_q, pkts_dropped_d;

    logic [N_INPUTS-1:0]    eligible;
    logic                   found;
    logic [IdxW-1:0]        sel_idx;
    int                     search_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic                   sel_bad;
    logic                   cmd_fire;
    logic                   cmd_stream;
    logic                   cmd_drop;
    logic                   g_valid;
    logic [FLIT_SIZE-1:0]   g_flit;
    logic [CntW-1:0]        cnt_inc;
    logic [IdleW-1:0]       idle_inc;
    logic                   last_flit;

    // Advance a buffer index by one, wrapping at N_INPUTS so that
    // non-power-of-two input counts rotate correctly.
    function automatic logic [IdxW-1:0] nextIdx(input logic [IdxW-1:0] g);
        if (int'(g) == N_INPUTS - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    assign eligible = packet_ready_i & control_ready_i;

    // Round-robin search: walk the inputs starting at the pointer and take
    // the first one that has a packet and can accept a command.
    always_comb begin
        found      = 1'b0;
        sel_idx    = rr_q;
        search_idx = 0;
        for (int k = 0; k < N_INPUTS; k++) begin
            search_idx = int'(rr_q) + k;
            if (search_idx >= N_INPUTS) begin
                search_idx = search_idx - N_INPUTS;
            end
            if (!found && eligible[IdxW'(search_idx)]) begin
                found   = 1'b1;
                sel_idx = IdxW'(search_idx);
            end
        end
    end

    // Header fields of the candidate and of the buffer currently streaming.
    // Done as compare-and-select loops so every slice has a constant base.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        g_valid  = 1'b0;
        g_flit   = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel_idx == IdxW'(i)) begin
                sel_addr = to_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = packet_length_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
            if (grant_q == IdxW'(i)) begin
                g_valid = in_flit_valid_i[i];
                g_flit  = in_flit_i[i*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    // A packet is dropped instead of streamed when it is empty, longer than
    // the link allows, or addressed outside this link's range. Commands are
    // only issued from IDLE and never during the reset cycle.
    always_comb begin
        sel_bad = 1'b0;
        if (int'(sel_len) == 0 || int'(sel_len) > MAX_LEN ||
            int'(sel_addr) < ADDR_LO || int'(sel_addr) > ADDR_HI) begin
            sel_bad = 1'b1;
        end
        cmd_fire   = (state_q == IDLE) && found && !rst_i;
        cmd_stream = cmd_fire && !sel_bad;
        cmd_drop   = cmd_fire && sel_bad;
    end

    // Drive the one-hot command strobe toward the selected buffer.
    always_comb begin
        control_valid_o = '0;
        stream_o        = '0;
        drop_o          = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (cmd_fire && sel_idx == IdxW'(i)) begin
                control_valid_o[i] = 1'b1;
                stream_o[i]        = !sel_bad;
                drop_o[i]          = sel_bad;
            end
        end
    end

    // Counter increments. cnt is one bit wider than the length so that the
    // final-flit compare can never wrap.
    assign cnt_inc   = cnt_q + 1'b1;
    assign idle_inc  = idle_cnt_q + 1'b1;
    assign last_flit = (cnt_inc == {1'b0, len_q});

    // Next-state logic. IDLE issues commands; STREAM forwards flits from the
    // granted buffer only, finishes on the last flit, and gives up after
    // TIMEOUT consecutive idle cycles. The pointer moves past whichever
    // buffer was just served, however its turn ended.
    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        grant_d          = grant_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        idle_cnt_d       = idle_cnt_q;
        out_flit_d       = out_flit_q;
        out_flit_valid_d = 1'b0;
        timeout_err_d    = timeout_err_q;
        pkts_streamed_d  = pkts_streamed_q;
        pkts_dropped_d   = pkts_dropped_q;

        case (state_q)
            IDLE: begin
                if (cmd_stream) begin
                    grant_d    = sel_idx;
                    len_d      = sel_len;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = STREAM;
                end else if (cmd_drop) begin
                    pkts_dropped_d = pkts_dropped_q + 16'd1;
                    rr_d           = nextIdx(sel_idx);
                end
            end
            STREAM: begin
                if (g_valid) begin
                    out_flit_d       = g_flit;
                    out_flit_valid_d = 1'b1;
                    cnt_d            = cnt_inc;
                    idle_cnt_d       = '0;
                    if (last_flit) begin
                        state_d         = IDLE;
                        pkts_streamed_d = pkts_streamed_q + 16'd1;
                        rr_d            = nextIdx(grant_q);
                    end
                end else if (int'(idle_inc) >= TIMEOUT) begin
                    timeout_err_d = 1'b1;
                    idle_cnt_d    = '0;
                    state_d       = IDLE;
                    rr_d          = nextIdx(grant_q);
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset takes effect immediately, even mid-stream,
    // clearing every counter, the pointer and the output link.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            rr_q             <= '0;
            grant_q          <= '0;
            len_q            <= '0;
            cnt_q            <= '0;
            idle_cnt_q       <= '0;
            out_flit_q       <= '0;
            out_flit_valid_q <= 1'b0;
            timeout_err_q    <= 1'b0;
            pkts_streamed_q  <= '0;
            pkts_dropped_q   <= '0;
        end else begin
            state_q          <= state_d;
            rr_q             <= rr_d;
            grant_q          <= grant_d;
            len_q            <= len_d;
            cnt_q            <= cnt_d;
            idle_cnt_q       <= idle_cnt_d;
            out_flit_q       <= out_flit_d;
            out_flit_valid_q <= out_flit_valid_d;
            timeout_err_q    <= timeout_err_d;
            pkts_streamed_q  <= pkts_streamed_d;
            pkts_dropped_q   <= pkts_dropped_d;
        end
    end

    assign out_flit_o       = out_flit_q;
    assign out_flit_valid_o = out_flit_valid_q;
    assign busy_o           = (state_q == STREAM);
    assign timeout_err_o    = timeout_err_q;
    assign pkts_streamed_o  = pkts_streamed_q;
    assign pkts_dropped_o   = pkts_dropped_q;

endmodule

// File: tb/tb_packet_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_packet_output_arbiter
//
// Purpose:
//   Directed bench for packet_output_arbiter with four inputs, address range
//   [0,8] and an eight-cycle stream timeout. Inputs change on the falling
//   edge and outputs are compared 1 time unit later, away from the rising
//   edge the design uses.
// ---------------------------------------------------------------------------
module tb_packet_output_arbiter;

    localparam int N  = 4;
    localparam int FW = 64;
    localparam int AW = 8;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    packet_ready;
    logic [N-1:0]    control_ready;
    logic [N-1:0]    in_flit_valid;
    logic [AW-1:0]   addrArr [N];
    logic [LW-1:0]   lenArr  [N];
    logic [FW-1:0]   flitArr [N];
    logic [N*AW-1:0] to_addr;
    logic [N*LW-1:0] packet_length;
    logic [N*FW-1:0] in_flit;

    logic [N-1:0]    control_valid;
    logic [N-1:0]    stream;
    logic [N-1:0]    drop;
    logic [FW-1:0]   out_flit;
    logic            out_flit_valid;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     pkts_streamed;
    logic [15:0]     pkts_dropped;

    int checks;
    int errors;
    int g;
    int order [5];
    logic [FW-1:0] prevData;

    assign to_addr       = {addrArr[3], addrArr[2], addrArr[1], addrArr[0]};
    assign packet_length = {lenArr[3], lenArr[2], lenArr[1], lenArr[0]};
    assign in_flit       = {flitArr[3], flitArr[2], flitArr[1], flitArr[0]};

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    packet_output_arbiter #(
        .N_INPUTS   (N),
        .FLIT_SIZE  (FW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .ADDR_LO    (0),
        .ADDR_HI    (8),
        .MAX_LEN    (255),
        .TIMEOUT    (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .packet_ready_i   (packet_ready),
        .control_ready_i  (control_ready),
        .to_addr_i        (to_addr),
        .packet_length_i  (packet_length),
        .in_flit_i        (in_flit),
        .in_flit_valid_i  (in_flit_valid),
        .control_valid_o  (control_valid),
        .stream_o         (stream),
        .drop_o           (drop),
        .out_flit_o       (out_flit),
        .out_flit_valid_o (out_flit_valid),
        .busy_o           (busy),
        .timeout_err_o    (timeout_err),
        .pkts_streamed_o  (pkts_streamed),
        .pkts_dropped_o   (pkts_dropped)
    );

    // Set the header fields and readiness of one upstream buffer.
    task automatic applyStimulus(input int i, input logic [AW-1:0] addr,
                                 input logic [LW-1:0] len, input logic rdy);
        addrArr[i]       = addr;
        lenArr[i]        = len;
        packet_ready[i]  = rdy;
        control_ready[i] = rdy;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [N-1:0] oneHot(input int i);
        return 4'b0001 << i;
    endfunction

    function automatic logic [FW-1:0] fairData(input int k, input int j);
        return 64'hF000_0000_0000_0000 | (64'(k) << 8) | 64'(j);
    endfunction

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed sequence: reset, single stream, drop rules, fairness, noise
    // rejection, timeout and reset mid-stream.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        packet_ready  = '0;
        control_ready = '0;
        in_flit_valid = '0;
        for (int k = 0; k < N; k++) begin
            addrArr[k] = '0;
            lenArr[k]  = '0;
            flitArr[k] = '0;
        end
        order = '{1, 2, 3, 0, 1};
        prevData = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_cv", control_valid, 0);
        checkOutput("rst_ofv", out_flit_valid, 0);
        checkOutput("rst_oflit", out_flit, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_terr", timeout_err, 0);
        checkOutput("rst_streamed", pkts_streamed, 0);
        checkOutput("rst_dropped", pkts_dropped, 0);
        rst = 1'b0;

        // Single stream: input 0, address 5, three flits.
        @(negedge clk);
        applyStimulus(0, 8'd5, 8'd3, 1'b1);
        #1;
        checkOutput("s1_cv", control_valid, 4'b0001);
        checkOutput("s1_stream", stream, 4'b0001);
        checkOutput("s1_drop", drop, 0);
        @(negedge clk);
        applyStimulus(0, 8'd5, 8'd3, 1'b0);
        in_flit_valid = 4'b0001;
        flitArr[0] = 64'hA1;
        #1;
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_cv_off", control_valid, 0);
        checkOutput("s1_ofv_pre", out_flit_valid, 0);
        @(negedge clk);
        flitArr[0] = 64'hA2;
        #1;
        checkOutput("s1_f0", out_flit, 64'hA1);
        checkOutput("s1_f0v", out_flit_valid, 1);
        @(negedge clk);
        flitArr[0] = 64'hA3;
        #1;
        checkOutput("s1_f1", out_flit, 64'hA2);
        checkOutput("s1_busy_last", busy, 1);
        @(negedge clk);
        in_flit_valid = '0;
        #1;
        checkOutput("s1_f2", out_flit, 64'hA3);
        checkOutput("s1_f2v", out_flit_valid, 1);
        checkOutput("s1_busy_done", busy, 0);
        checkOutput("s1_streamed", pkts_streamed, 1);
        @(negedge clk);
        #1;
        checkOutput("s1_ofv_end", out_flit_valid, 0);

        // Drop rules with pointer at 1: input 1 empty, input 2 out of range,
        // input 0 empty. Expected order 1, 2, then wrap to 0.
        @(negedge clk);
        applyStimulus(0, 8'd5, 8'd0, 1'b1);
        applyStimulus(1, 8'd5, 8'd0, 1'b1);
        applyStimulus(2, 8'd9, 8'd3, 1'b1);
        #1;
        checkOutput("d1_cv", control_valid, 4'b0010);
        checkOutput("d1_drop", drop, 4'b0010);
        checkOutput("d1_stream", stream, 0);
        @(negedge clk);
        applyStimulus(1, 8'd5, 8'd0, 1'b0);
        #1;
        checkOutput("d2_cv", control_valid, 4'b0100);
        checkOutput("d2_drop", drop, 4'b0100);
        checkOutput("d2_dropped", pkts_dropped, 1);
        @(negedge clk);
        applyStimulus(2, 8'd9, 8'd3, 1'b0);
        #1;
        checkOutput("d3_cv", control_valid, 4'b0001);
        checkOutput("d3_drop", drop, 4'b0001);
        checkOutput("d3_dropped", pkts_dropped, 2);
        checkOutput("d3_ofv", out_flit_valid, 0);
        @(negedge clk);
        applyStimulus(0, 8'd5, 8'd0, 1'b0);
        #1;
        checkOutput("d4_dropped", pkts_dropped, 3);
        checkOutput("d4_cv", control_valid, 0);
        checkOutput("d4_busy", busy, 0);

        // Fairness: all inputs eligible with two-flit packets, pointer at 1.
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 8'd1, 8'd2, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            g = order[k];
            #1;
            checkOutput("fair_cv", control_valid, oneHot(g));
            checkOutput("fair_stream", stream, oneHot(g));
            if (k > 0) begin
                checkOutput("fair_last", out_flit, prevData);
                checkOutput("fair_lastv", out_flit_valid, 1);
            end
            @(negedge clk);
            in_flit_valid = oneHot(g);
            flitArr[g] = fairData(k, 0);
            #1;
            checkOutput("fair_quiet", control_valid, 0);
            checkOutput("fair_gap", out_flit_valid, 0);
            checkOutput("fair_busy", busy, 1);
            @(negedge clk);
            flitArr[g] = fairData(k, 1);
            #1;
            checkOutput("fair_f0", out_flit, fairData(k, 0));
            checkOutput("fair_f0v", out_flit_valid, 1);
            @(negedge clk);
            in_flit_valid = '0;
            prevData = fairData(k, 1);
            if (k == 4) begin
                packet_ready = '0;
            end
        end
        #1;
        checkOutput("fair_tail", out_flit, prevData);
        checkOutput("fair_tailv", out_flit_valid, 1);
        checkOutput("fair_cv_end", control_valid, 0);
        checkOutput("fair_streamed", pkts_streamed, 6);
        control_ready = '0;

        // Noise: input 3 toggles valid while input 1 streams three flits.
        @(negedge clk);
        applyStimulus(1, 8'd7, 8'd3, 1'b1);
        in_flit_valid = 4'b1000;
        flitArr[3] = 64'hBAD0;
        #1;
        checkOutput("nz_cv", control_valid, 4'b0010);
        checkOutput("nz_stream", stream, 4'b0010);
        @(negedge clk);
        applyStimulus(1, 8'd7, 8'd3, 1'b0);
        in_flit_valid = 4'b0010;
        flitArr[1] = 64'h1110;
        #1;
        checkOutput("nz_idle_ofv", out_flit_valid, 0);
        @(negedge clk);
        in_flit_valid = 4'b1010;
        flitArr[1] = 64'h1111;
        flitArr[3] = 64'hBAD1;
        #1;
        checkOutput("nz_f0", out_flit, 64'h1110);
        checkOutput("nz_f0v", out_flit_valid, 1);
        @(negedge clk);
        in_flit_valid = 4'b0000;
        #1;
        checkOutput("nz_f1", out_flit, 64'h1111);
        @(negedge clk);
        in_flit_valid = 4'b1010;
        flitArr[1] = 64'h1112;
        flitArr[3] = 64'hBAD2;
        #1;
        checkOutput("nz_gap", out_flit_valid, 0);
        @(negedge clk);
        flitArr[1] = 64'h1113;
        #1;
        checkOutput("nz_f2", out_flit, 64'h1112);
        checkOutput("nz_f2v", out_flit_valid, 1);
        checkOutput("nz_busy", busy, 0);
        checkOutput("nz_streamed", pkts_streamed, 7);
        @(negedge clk);
        in_flit_valid = '0;
        #1;
        checkOutput("nz_extra", out_flit_valid, 0);

        // Timeout: input 2, four-flit packet, only two flits delivered.
        @(negedge clk);
        applyStimulus(2, 8'd3, 8'd4, 1'b1);
        #1;
        checkOutput("to_cv", control_valid, 4'b0100);
        checkOutput("to_stream", stream, 4'b0100);
        @(negedge clk);
        applyStimulus(2, 8'd3, 8'd4, 1'b0);
        in_flit_valid = 4'b0100;
        flitArr[2] = 64'h7770;
        @(negedge clk);
        flitArr[2] = 64'h7771;
        #1;
        checkOutput("to_f0", out_flit, 64'h7770);
        @(negedge clk);
        in_flit_valid = '0;
        #1;
        checkOutput("to_f1", out_flit, 64'h7771);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput("to_busy", busy, (i < 8));
            checkOutput("to_err", timeout_err, (i >= 8));
        end
        checkOutput("to_streamed", pkts_streamed, 7);
        checkOutput("to_ofv", out_flit_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("to_sticky", timeout_err, 1);

        // Reset mid-stream: input 3 streams two of five flits, then reset.
        @(negedge clk);
        applyStimulus(3, 8'd2, 8'd5, 1'b1);
        #1;
        checkOutput("rs_cv", control_valid, 4'b1000);
        @(negedge clk);
        in_flit_valid = 4'b1000;
        flitArr[3] = 64'hC0;
        @(negedge clk);
        flitArr[3] = 64'hC1;
        #1;
        checkOutput("rs_f0", out_flit, 64'hC0);
        @(negedge clk);
        rst = 1'b1;
        flitArr[3] = 64'hC2;
        applyStimulus(0, 8'd1, 8'd2, 1'b1);
        #1;
        checkOutput("rs_nocmd", control_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        in_flit_valid = '0;
        #1;
        checkOutput("rs_ofv", out_flit_valid, 0);
        checkOutput("rs_oflit", out_flit, 0);
        checkOutput("rs_busy", busy, 0);
        checkOutput("rs_terr", timeout_err, 0);
        checkOutput("rs_streamed", pkts_streamed, 0);
        checkOutput("rs_dropped", pkts_dropped, 0);
        checkOutput("rs_fresh_cv", control_valid, 4'b0001);
        checkOutput("rs_fresh_stream", stream, 4'b0001);
        @(negedge clk);
        packet_ready  = '0;
        control_ready = '0;
        in_flit_valid = 4'b0001;
        flitArr[0] = 64'hD0;
        #1;
        checkOutput("rs_busy2", busy, 1);
        @(negedge clk);
        flitArr[0] = 64'hD1;
        #1;
        checkOutput("rs_f0b", out_flit, 64'hD0);
        @(negedge clk);
        in_flit_valid = '0;
        #1;
        checkOutput("rs_f1b", out_flit, 64'hD1);
        checkOutput("rs_streamed2", pkts_streamed, 1);
        checkOutput("rs_busy3", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
